mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store controller. Receives one instruction per handshake from the execute-stage pipeline register outputs, issues the matching request on the data-memory bus, and aligns, sign-extends or zero-extends load data. Presents the result to the writeback-stage register with a valid/ready handshake, and provides the stall and flush hooks the pipeline control needs.

## Interface
- ALIGN_CHECK, 1: when 1, misaligned accesses are trapped; when 0, they are issued as-is.
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  execute-stage result valid.
- in_ready  out  1  LSU can accept.
- in_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- in_size  in  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- in_addr  in  64  effective address.
- in_wdata  in  64  store data, right-aligned.
- in_alu  in  64  ALU result; forwarded for non-memory ops.
- in_rd  in  5  destination register.
- flush  in  1  kill the in-flight instruction.
- mem_req, mem_we  out  1  bus request and write enable.
- mem_addr  out  64  {in_addr[63:3], 3'b0}.
- mem_wdata  out  64  lane-shifted store data.
- mem_wstrb  out  8  byte strobes.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data or write acknowledge.
- mem_rdata  in  64  read data.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback stage accepts.
- out_data  out  64  load data or in_alu.
- out_rd  out  5  destination register.
- out_misalign  out  1  misaligned-access exception.
- stall  out  1  equals in_valid & ~in_ready.

## Operation
- **States:** IDLE, REQ, WAIT, DRAIN, RESP.
- **in_ready:** in_ready = (state==IDLE).
- **Accept:** happens when in_valid & in_ready. Captures op, size, addr, wdata, alu and rd.
- **Misalignment:** with ALIGN_CHECK=1, a load or store is misaligned when addr[0] is set for h, addr[1:0]!=0 for w, or addr[2:0]!=0 for d.
- **IDLE transitions on accept:**
  - misaligned → RESP with out_misalign=1 and no bus request.
  - op none → RESP with out_data=in_alu.
  - load or store → REQ.
- **REQ:** mem_req=1. mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_gnt. On mem_gnt → WAIT.
- **WAIT:** on mem_rvalid → RESP, capturing load data. Stores also complete on mem_rvalid; out_data is then 0.
- **RESP:** out_valid=1. On out_ready → IDLE.
- **Store lanes** (lane = addr[2:0]):
  - wstrb: b 0x01<<lane, h 0x03<<lane, w 0x0F<<lane, d 0xFF.
  - wdata = in_wdata << (8*lane).
- **Load data:** r = mem_rdata >> (8*lane), then:
  - signed sizes sign-extend from bit 7, 15 or 31;
  - u sizes zero-extend;
  - d takes all 64 bits.
- **Flush:**
  - IDLE: the accept in that cycle is suppressed.
  - REQ before gnt: mem_req drops and the FSM goes to IDLE.
  - REQ in the same cycle as gnt: → DRAIN.
  - WAIT: → DRAIN.
  - DRAIN: waits for mem_rvalid, discards the response, → IDLE. out_valid is never asserted.
  - RESP: out_valid drops and the FSM goes to IDLE.
- **Simultaneous events:** flush wins over gnt, rvalid and out_ready for the result, but the bus transaction is always completed.
- **Bus protocol:** mem_rvalid is ignored outside WAIT and DRAIN. Slaves return rvalid at least one cycle after gnt, in order, and one transaction is outstanding at most.

## Timing
- **Reset values:** state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, out_valid=0, out_data=0, out_rd=0, out_misalign=0.
- **in_ready after reset:** 1 in the first cycle after reset deasserts.
- **Reset mid-transaction:** reset in any state returns to IDLE on the next edge. An outstanding bus response is abandoned; the bus is reset together with the LSU.
- **All outputs registered** except in_ready and stall, which decode from state.
- **Load latency:** accept at T, mem_req at T+1; with gnt at T+1 and rvalid at T+2, out_valid is at T+3.
- **Non-memory op latency:** accept at T, out_valid at T+1.
- **Throughput:** one instruction per 2 cycles for non-memory ops (IDLE↔RESP).

## Structure
- **Package lsu_pkg:**
  - op codes (OP_NONE, OP_LOAD, OP_STORE);
  - funct3 size codes;
  - state enum;
  - function is_misaligned(size, addr[2:0]).
- **Sub-module lsu_align (combinational):**
  - store path: size and lane → wstrb and wdata;
  - load path: size, lane and rdata → extended data.
- **Top level:** FSM and capture registers only.

## Test plan
- **lbu/lb:** load, size 100, addr 0x8000_0003, rdata 0x1122_3344_5566_7788.
  - Required: out_data=0x0000_0000_0000_0055.
  - Repeat with lb at lane 0 on rdata 0x..80: out_data=0xFFFF_FFFF_FFFF_FF80.
- **sh:** store, size 001, addr 0x...6, wdata 0xABCD.
  - Required: mem_wstrb=0xC0, mem_wdata=0xABCD_0000_0000_0000, mem_addr aligned.
  - mem_req is held across a 3-cycle gnt delay.
- **Misaligned lw:** load, size 010, addr 0x...2, ALIGN_CHECK=1.
  - Required: no mem_req; out_misalign=1 at T+1.
- **Flush in WAIT:** flush while in WAIT, rvalid 2 cycles later.
  - Required: DRAIN consumes the rvalid, out_valid stays 0, then in_ready=1.
- **Back-pressure:** out_ready low for 4 cycles during RESP.
  - Required: out_valid and out_data held, in_ready=0, stall=1 while in_valid is high.
- **Reset in REQ:** rst asserted while in REQ.
  - Required: next cycle mem_req=0, out_valid=0, in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared codes for the memory-stage LSU: op/size encodings, FSM states and
// the alignment rule used at accept time.
package lsu_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  // Byte accesses can never be misaligned; the encoding 3'b111 is treated as d.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] a);
    case (size)
      SZ_B, SZ_BU: return 1'b0;
      SZ_H, SZ_HU: return a[0];
      SZ_W, SZ_WU: return a[1:0] != 2'b00;
      SZ_D:        return a != 3'b000;
      default:     return a != 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobes toward the bus lane, load data back
// down from the lane with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [2:0]  st_lane_i,
  input  logic [63:0] st_data_i,
  output logic [7:0]  st_strb_o,
  output logic [63:0] st_data_o,
  input  logic [2:0]  ld_size_i,
  input  logic [2:0]  ld_lane_i,
  input  logic [63:0] ld_rdata_i,
  output logic [63:0] ld_data_o
);

  logic [63:0] ld_sh;

  always_comb begin
    case (st_size_i)
      SZ_B, SZ_BU: st_strb_o = 8'h01 << st_lane_i;
      SZ_H, SZ_HU: st_strb_o = 8'h03 << st_lane_i;
      SZ_W, SZ_WU: st_strb_o = 8'h0F << st_lane_i;
      default:     st_strb_o = 8'hFF;
    endcase
  end

  assign st_data_o = st_data_i << {st_lane_i, 3'b000};
  assign ld_sh     = ld_rdata_i >> {ld_lane_i, 3'b000};

  always_comb begin
    case (ld_size_i)
      SZ_B:    ld_data_o = {{56{ld_sh[7]}}, ld_sh[7:0]};
      SZ_BU:   ld_data_o = {56'd0, ld_sh[7:0]};
      SZ_H:    ld_data_o = {{48{ld_sh[15]}}, ld_sh[15:0]};
      SZ_HU:   ld_data_o = {48'd0, ld_sh[15:0]};
      SZ_W:    ld_data_o = {{32{ld_sh[31]}}, ld_sh[31:0]};
      SZ_WU:   ld_data_o = {32'd0, ld_sh[31:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store controller: one instruction in flight, single
// outstanding bus transaction, registered result toward writeback.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter logic ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_size,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [63:0] in_alu,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_misalign,
  output logic        stall
);

  state_t      state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  lane_q, lane_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wstrb_q, mem_wstrb_d;
  logic        out_valid_q, out_valid_d, out_mis_q, out_mis_d;
  logic [63:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;

  logic        accept, is_mem, is_store, misal;
  logic [7:0]  st_strb;
  logic [63:0] st_data, ld_data;

  assign in_ready = (state_q == ST_IDLE);
  assign stall    = in_valid & ~in_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign is_store = (in_op == OP_STORE);
  assign is_mem   = (in_op == OP_LOAD) | is_store;
  assign misal    = ALIGN_CHECK & is_mem & is_misaligned(in_size, in_addr[2:0]);

  lsu_align u_align (
    .st_size_i  (in_size),
    .st_lane_i  (in_addr[2:0]),
    .st_data_i  (in_wdata),
    .st_strb_o  (st_strb),
    .st_data_o  (st_data),
    .ld_size_i  (size_q),
    .ld_lane_i  (lane_q),
    .ld_rdata_i (mem_rdata),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    lane_d      = lane_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    out_mis_d   = out_mis_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          size_d   = in_size;
          lane_d   = in_addr[2:0];
          out_rd_d = in_rd;
          if (misal) begin
            state_d    = ST_RESP;
            out_mis_d  = 1'b1;
            out_data_d = '0;
          end else if (!is_mem || in_op == OP_NONE) begin
            state_d    = ST_RESP;
            out_mis_d  = 1'b0;
            out_data_d = in_alu;
          end else begin
            state_d     = ST_REQ;
            out_mis_d   = 1'b0;
            mem_we_d    = is_store;
            mem_addr_d  = {in_addr[63:3], 3'b000};
            mem_wdata_d = is_store ? st_data : '0;
            mem_wstrb_d = is_store ? st_strb : '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt)    state_d = flush ? ST_DRAIN : ST_WAIT;
        else if (flush) state_d = ST_IDLE;
      end
      // A flush coinciding with rvalid has nothing left to drain.
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (flush) state_d = ST_IDLE;
          else begin
            state_d    = ST_RESP;
            out_data_d = mem_we_q ? '0 : ld_data;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (mem_rvalid) state_d = ST_IDLE;
      ST_RESP:  if (flush || out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    mem_req_d   = (state_d == ST_REQ);
    out_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      lane_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      out_mis_q   <= out_mis_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_rd       = out_rd_q;
  assign out_misalign = out_mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_size;
  logic [63:0] in_addr, in_wdata, in_alu;
  logic [4:0]  in_rd;
  logic        flush;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_misalign, stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu(in_alu), .in_rd(in_rd), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_misalign(out_misalign), .stall(stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int nbytes(input logic [2:0] size);
    case (size[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 8;
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [2:0] size, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] alu, input logic [4:0] rd,
                       input logic [63:0] rdata, input int gd, input int rvd, input int bp);
    int nb, lane;
    bit mem, st, mis;
    logic [63:0] exp_d, exp_wd;
    logic [7:0]  exp_s;
    nb   = nbytes(size);
    lane = int'(addr[2:0]);
    mem  = (op == 2'b01) || (op == 2'b10);
    st   = (op == 2'b10);
    mis  = mem && (lane % nb != 0);
    exp_s = '0; exp_wd = '0; exp_d = '0;
    for (int j = 0; j < 8; j++) if (j >= lane) exp_wd[8*j +: 8] = wd[8*(j-lane) +: 8];
    if (nb == 8) exp_s = 8'hFF;
    else for (int k = 0; k < nb; k++) if (lane + k < 8) exp_s[lane+k] = 1'b1;
    for (int k = 0; k < nb; k++) if (lane + k < 8) exp_d[8*k +: 8] = rdata[8*(lane+k) +: 8];
    if (!size[2] && nb < 8 && exp_d[8*nb-1])
      for (int k = nb; k < 8; k++) exp_d[8*k +: 8] = 8'hFF;
    if (mis) exp_d = '0;
    else if (!mem) exp_d = alu;
    else if (st) exp_d = '0;

    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_op = op; in_size = size; in_addr = addr;
    in_wdata = wd; in_alu = alu; in_rd = rd;
    tick();
    in_valid = 1'b0;
    if (mem && !mis) begin
      chk("mem_req", mem_req, 1'b1);
      chk("mem_we", mem_we, st);
      chk("mem_addr", mem_addr, {addr[63:3], 3'b000});
      if (st) begin
        chk("mem_wstrb", mem_wstrb, exp_s);
        chk("mem_wdata", mem_wdata, exp_wd);
      end
      for (int i = 0; i < gd; i++) begin
        tick();
        chk("mem_req_hold", mem_req, 1'b1);
        chk("mem_addr_hold", mem_addr, {addr[63:3], 3'b000});
        if (st) chk("mem_wstrb_hold", mem_wstrb, exp_s);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("mem_req_drop", mem_req, 1'b0);
      for (int i = 0; i < rvd; i++) begin
        tick();
        chk("no_early_valid", out_valid, 1'b0);
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      tick();
      mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
    end else begin
      chk("no_mem_req", mem_req, 1'b0);
    end
    chk("out_valid", out_valid, 1'b1);
    chk("out_data", out_data, exp_d);
    chk("out_rd", out_rd, rd);
    chk("out_misalign", out_misalign, mis);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1; in_op = 2'b00;
      #1;
      chk("bp_stall", stall, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_data_held", out_data, exp_d);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("retire_valid", out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_size = 0; in_addr = 0; in_wdata = 0;
    in_alu = 0; in_rd = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    out_ready = 0;
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wstrb", mem_wstrb, 8'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    do_op(2'b01, 3'b100, 64'h8000_0003, 64'h0, 64'h0, 5'd1, 64'h1122_3344_5566_7788, 0, 0, 0);
    do_op(2'b01, 3'b000, 64'h8000_0000, 64'h0, 64'h0, 5'd2, 64'h1122_3344_5566_7780, 0, 0, 0);
    do_op(2'b10, 3'b001, 64'h8000_1006, 64'hABCD, 64'h0, 5'd3, 64'h0, 3, 1, 0);
    do_op(2'b01, 3'b010, 64'h8000_0002, 64'h0, 64'h0, 5'd4, 64'h0, 0, 0, 0);
    do_op(2'b00, 3'b000, 64'h0, 64'h0, 64'hDEAD_BEEF_0123_4567, 5'd5, 64'h0, 0, 0, 4);

    in_valid = 1; in_op = 2'b01; in_size = 3'b011; in_addr = 64'h100; in_rd = 5'd6;
    tick(); in_valid = 0;
    mem_gnt = 1; tick(); mem_gnt = 0;
    flush = 1; tick(); flush = 0;
    chk("drain_in_ready", in_ready, 1'b0);
    tick();
    chk("drain_valid", out_valid, 1'b0);
    mem_rvalid = 1; mem_rdata = 64'h55; tick(); mem_rvalid = 0;
    chk("drain_done_valid", out_valid, 1'b0);
    chk("drain_done_ready", in_ready, 1'b1);

    in_valid = 1; in_op = 2'b00; in_alu = 64'h77; flush = 1;
    tick(); in_valid = 0; flush = 0;
    chk("flush_idle_valid", out_valid, 1'b0);
    chk("flush_idle_ready", in_ready, 1'b1);

    in_valid = 1; in_op = 2'b10; in_size = 3'b010; in_addr = 64'h208;
    tick(); in_valid = 0;
    flush = 1; tick(); flush = 0;
    chk("flush_req_memreq", mem_req, 1'b0);
    chk("flush_req_ready", in_ready, 1'b1);

    in_valid = 1; in_op = 2'b00; in_alu = 64'h99;
    tick(); in_valid = 0;
    chk("resp_valid", out_valid, 1'b1);
    flush = 1; tick(); flush = 0;
    chk("flush_resp_valid", out_valid, 1'b0);

    in_valid = 1; in_op = 2'b01; in_size = 3'b000; in_addr = 64'h301;
    tick(); in_valid = 0;
    chk("pre_rst_req", mem_req, 1'b1);
    rst = 1; tick();
    chk("rst_req_memreq", mem_req, 1'b0);
    chk("rst_req_valid", out_valid, 1'b0);
    rst = 0; #1;
    chk("rst_req_ready", in_ready, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      do_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)), a, {$urandom, $urandom},
            {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
